video_mem_responder: RTL
========================

VIDEO_MEM_RESPONDER -- requirements
Module: video_mem_responder

Interface
REQ-001 SHALL have parameter RAM_BYTES, default 8192, main RAM size at 0x0000.
REQ-002 SHALL have parameter ROM_BASE, default 16'h8000, base of the 4 KB char ROM region.
REQ-003 SHALL have parameter COLOR_BASE, default 16'h9400, base of the 1 K x 4 colour RAM region.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-006 SHALL have port vga_addr  input  16  video fetch address, sampled every cycle.
REQ-007 SHALL have port vga_data  output  8  video fetch data, registered.
REQ-008 SHALL have port cpu_addr  input  16  CPU address.
REQ-009 SHALL have port cpu_din  input  8  CPU write data.
REQ-010 SHALL have port cpu_we  input  1  1 = write, 0 = read.
REQ-011 SHALL have port cpu_req  input  1  CPU request, level, held until ack.
REQ-012 SHALL have port cpu_ack  output  1  one-cycle completion pulse.
REQ-013 SHALL have port cpu_dout  output  8  CPU read data, valid while cpu_ack=1.
REQ-014 SHALL have port dl_valid  input  1  download byte strobe.
REQ-015 SHALL have port dl_byte  input  8  download byte.
REQ-016 SHALL have port dl_start  input  1  restart download framing.
REQ-017 SHALL have port dl_busy  output  1  high while a download write is pending.

Function
REQ-018 Region decode: RAM 0x0000..RAM_BYTES-1; ROM ROM_BASE..+0xFFF; colour COLOR_BASE..+0x3FF; anything else unmapped.
REQ-019 Video read: vga_data SHALL equal memory at the vga_addr sampled on the previous rising edge (latency exactly 1), every cycle, with no stalls.
REQ-020 Colour reads SHALL return {4'h0, nibble}; unmapped reads SHALL return 8'hFF.
REQ-021 Video port SHALL be read-only and independent of the CPU and loader ports (dual-port storage).
REQ-022 Write port FSM states: IDLE, CPU_ACC, CPU_RESP; loader writes are serviced from IDLE.
REQ-023 IDLE with pending loader byte: perform the loader write; loader has priority over the CPU.
REQ-024 IDLE with cpu_req=1 and no pending loader byte: latch addr/din/we, go to CPU_ACC.
REQ-025 CPU_ACC: issue access, go to CPU_RESP; CPU_RESP: cpu_ack=1 for one cycle with cpu_dout valid, return to IDLE.
REQ-026 Minimum CPU latency SHALL be 3 cycles from cpu_req rise to cpu_ack; a new request SHALL NOT be accepted in the cycle cpu_ack=1.
REQ-027 CPU writes to the ROM or unmapped regions SHALL be discarded but still acked; colour writes store din[3:0].
REQ-028 Loader framing: byte 1 = address high, byte 2 = address low, each later byte is written at that address, then the address is incremented modulo 2^16.
REQ-029 Loader writes SHALL reach all regions, including ROM; unmapped addresses are discarded.
REQ-030 Loader SHALL buffer one byte; dl_busy=1 from the dl_valid cycle until the write commits; a dl_valid arriving while busy SHALL be dropped.
REQ-031 dl_start=1 SHALL return framing to expect address high; dl_start has priority over a simultaneous dl_valid.
REQ-032 Same-address video read and write in one cycle SHALL return old data (read-first).

Reset
REQ-033 On reset=0 at a rising edge: FSM to IDLE, cpu_ack=0, cpu_dout=0, vga_data=0, dl_busy=0, framing to address high, pending loader byte discarded.
REQ-034 A CPU access in progress when reset asserts SHALL be abandoned without ack; memory contents SHALL be preserved.

Structure
REQ-035 Region bases/sizes, the region enum and FSM state encoding SHALL live in shared package vic_mem_pkg.
REQ-036 The loader framing/address counter SHALL be sub-module vic_mem_loader; storage arrays SHALL remain inside video_mem_responder.

Verification
REQ-037 Loader 0x80,0x00,0x3C,0x66 -> ROM[0x8000]=0x3C and ROM[0x8001]=0x66; vga_addr=0x8001 -> vga_data=0x66 one cycle later.
REQ-038 CPU write 0x9400<-0xA5, then read 0x9400 -> cpu_dout=0x05; video read of 0x9400 returns 0x05.
REQ-039 CPU write 0x8000<-0x00 after load -> cpu_ack pulses; ROM[0x8000] stays 0x3C.
REQ-040 cpu_req and dl_valid asserted in the same cycle -> loader write commits first, cpu_ack is delayed by at least 1 cycle, and both writes land.
REQ-041 Loader address 0xFF,0xFF, then data 0x11,0x22 -> 0xFFFF is discarded (unmapped), address wraps, RAM[0x0000]=0x22.
REQ-042 reset=0 asserted in CPU_ACC -> no cpu_ack; after release a new read of 0x1000 acks in 3 cycles with the prior contents.

Source files
------------

// File: rtl/vic_mem_pkg.sv
// rtl/vic_mem_pkg.sv - shared region map, region/state enums and address decode
package vic_mem_pkg;

  localparam int          RAM_BYTES_DEF  = 8192;
  localparam logic [15:0] ROM_BASE_DEF   = 16'h8000;
  localparam logic [15:0] COLOR_BASE_DEF = 16'h9400;
  localparam int          ROM_BYTES      = 4096;
  localparam int          COLOR_WORDS    = 1024;

  typedef enum logic [1:0] {REG_RAM, REG_ROM, REG_COLOR, REG_NONE} region_e;

  typedef enum logic [1:0] {ST_IDLE, ST_CPU_ACC, ST_CPU_RESP} wr_state_e;

  typedef enum logic [1:0] {FR_ADDR_HI, FR_ADDR_LO, FR_DATA} frame_e;

  // 17-bit compares so a region ending exactly at 0x10000 still decodes.
  function automatic region_e decode_region(input logic [15:0] addr,
                                            input logic [16:0] ram_bytes,
                                            input logic [15:0] rom_base,
                                            input logic [15:0] color_base);
    logic [16:0] a;
    region_e     r;
    a = {1'b0, addr};
    if (a < ram_bytes)
      r = REG_RAM;
    else if (a >= {1'b0, rom_base} && a < ({1'b0, rom_base} + 17'(ROM_BYTES)))
      r = REG_ROM;
    else if (a >= {1'b0, color_base} && a < ({1'b0, color_base} + 17'(COLOR_WORDS)))
      r = REG_COLOR;
    else
      r = REG_NONE;
    return r;
  endfunction

endpackage

// File: rtl/vic_mem_loader.sv
// rtl/vic_mem_loader.sv - download framing, address counter and one-byte write buffer
module vic_mem_loader
  import vic_mem_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        dl_valid,
  input  logic [7:0]  dl_byte,
  input  logic        dl_start,
  input  logic        commit,
  output logic        pending,
  output logic        accept_data,
  output logic        busy,
  output logic [15:0] wr_addr,
  output logic [7:0]  wr_data
);

  frame_e      frame_q, frame_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic        pend_q, pend_d;
  logic        take;

  always_comb begin
    frame_d = frame_q;
    addr_d  = addr_q;
    data_d  = data_q;
    pend_d  = pend_q;
    // Bytes arriving while a write is still buffered are dropped outright.
    take        = reset && dl_valid && !dl_start && !pend_q;
    accept_data = take && (frame_q == FR_DATA);

    if (commit) begin
      pend_d = 1'b0;
      addr_d = addr_q + 16'd1;
    end

    if (dl_start) begin
      frame_d = FR_ADDR_HI;
    end else if (take) begin
      case (frame_q)
        FR_ADDR_HI: begin
          addr_d[15:8] = dl_byte;
          frame_d      = FR_ADDR_LO;
        end
        FR_ADDR_LO: begin
          addr_d[7:0] = dl_byte;
          frame_d     = FR_DATA;
        end
        default: begin
          data_d = dl_byte;
          pend_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      frame_q <= FR_ADDR_HI;
      addr_q  <= 16'h0000;
      data_q  <= 8'h00;
      pend_q  <= 1'b0;
    end else begin
      frame_q <= frame_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      pend_q  <= pend_d;
    end
  end

  assign pending = pend_q;
  assign busy    = pend_q || accept_data;
  assign wr_addr = addr_q;
  assign wr_data = data_q;

endmodule

// File: rtl/video_mem_responder.sv
// rtl/video_mem_responder.sv - dual-port video memory: read-only video port, CPU/loader write port
module video_mem_responder
  import vic_mem_pkg::*;
#(
  parameter int          RAM_BYTES  = RAM_BYTES_DEF,
  parameter logic [15:0] ROM_BASE   = ROM_BASE_DEF,
  parameter logic [15:0] COLOR_BASE = COLOR_BASE_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] vga_addr,
  output logic [7:0]  vga_data,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_din,
  input  logic        cpu_we,
  input  logic        cpu_req,
  output logic        cpu_ack,
  output logic [7:0]  cpu_dout,
  input  logic        dl_valid,
  input  logic [7:0]  dl_byte,
  input  logic        dl_start,
  output logic        dl_busy
);

  localparam int RAM_AW = $clog2(RAM_BYTES);

  logic [7:0] ram   [RAM_BYTES];
  logic [7:0] rom   [ROM_BYTES];
  logic [3:0] color [COLOR_WORDS];

  wr_state_e   state_q, state_d;
  logic [15:0] cpu_addr_q, cpu_addr_d;
  logic [7:0]  cpu_din_q, cpu_din_d;
  logic        cpu_we_q, cpu_we_d;
  logic [7:0]  cpu_dout_q, cpu_dout_d;
  logic [7:0]  vga_data_q, vga_data_d;
  logic [7:0]  cpu_rd_data;

  logic        mem_we;
  logic        mem_rom_ok;
  logic [15:0] mem_waddr;
  logic [7:0]  mem_wdata;
  region_e     mem_region;

  logic        ld_pending, ld_accept, ld_commit;
  logic [15:0] ld_addr;
  logic [7:0]  ld_data;

  function automatic logic [7:0] mem_read(input logic [15:0] a);
    logic [7:0] r;
    r = 8'hFF;
    case (decode_region(a, 17'(RAM_BYTES), ROM_BASE, COLOR_BASE))
      REG_RAM:   r = ram[a[RAM_AW-1:0]];
      REG_ROM:   r = rom[a[11:0] - ROM_BASE[11:0]];
      REG_COLOR: r = {4'h0, color[a[9:0] - COLOR_BASE[9:0]]};
      default:   r = 8'hFF;
    endcase
    return r;
  endfunction

  vic_mem_loader u_loader (
    .clk         (clk),
    .reset       (reset),
    .dl_valid    (dl_valid),
    .dl_byte     (dl_byte),
    .dl_start    (dl_start),
    .commit      (ld_commit),
    .pending     (ld_pending),
    .accept_data (ld_accept),
    .busy        (dl_busy),
    .wr_addr     (ld_addr),
    .wr_data     (ld_data)
  );

  always_comb begin
    vga_data_d  = mem_read(vga_addr);
    cpu_rd_data = mem_read(cpu_addr_q);
  end

  always_comb begin
    state_d    = state_q;
    cpu_addr_d = cpu_addr_q;
    cpu_din_d  = cpu_din_q;
    cpu_we_d   = cpu_we_q;
    cpu_dout_d = cpu_dout_q;
    mem_we     = 1'b0;
    mem_rom_ok = 1'b0;
    mem_waddr  = cpu_addr_q;
    mem_wdata  = cpu_din_q;
    ld_commit  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // A loader byte arriving this cycle also blocks the CPU so it lands first.
        if (ld_pending) begin
          mem_we     = 1'b1;
          mem_rom_ok = 1'b1;
          mem_waddr  = ld_addr;
          mem_wdata  = ld_data;
          ld_commit  = 1'b1;
        end else if (!ld_accept && cpu_req) begin
          cpu_addr_d = cpu_addr;
          cpu_din_d  = cpu_din;
          cpu_we_d   = cpu_we;
          state_d    = ST_CPU_ACC;
        end
      end
      ST_CPU_ACC: begin
        mem_we = cpu_we_q;
        if (!cpu_we_q) cpu_dout_d = cpu_rd_data;
        state_d = ST_CPU_RESP;
      end
      ST_CPU_RESP: state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase

    if (!reset) begin
      mem_we    = 1'b0;
      ld_commit = 1'b0;
    end
  end

  assign mem_region = decode_region(mem_waddr, 17'(RAM_BYTES), ROM_BASE, COLOR_BASE);

  // Storage has no reset so contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      case (mem_region)
        REG_RAM:   ram[mem_waddr[RAM_AW-1:0]] <= mem_wdata;
        REG_ROM:   if (mem_rom_ok) rom[mem_waddr[11:0] - ROM_BASE[11:0]] <= mem_wdata;
        REG_COLOR: color[mem_waddr[9:0] - COLOR_BASE[9:0]] <= mem_wdata[3:0];
        default:   ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cpu_addr_q <= 16'h0000;
      cpu_din_q  <= 8'h00;
      cpu_we_q   <= 1'b0;
      cpu_dout_q <= 8'h00;
      vga_data_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      cpu_addr_q <= cpu_addr_d;
      cpu_din_q  <= cpu_din_d;
      cpu_we_q   <= cpu_we_d;
      cpu_dout_q <= cpu_dout_d;
      vga_data_q <= vga_data_d;
    end
  end

  assign cpu_ack  = (state_q == ST_CPU_RESP);
  assign cpu_dout = cpu_dout_q;
  assign vga_data = vga_data_q;

endmodule
